// File: rtl/pit_table.sv
// Pending Interest Table: aggregates interests, forwards misses to the FIB with a
// minimum spacing, and serves the PIT end of the FIB data-return handshake.
module pit_table #(
    parameter int ENTRIES    = 8,
    parameter int DATA_BYTES = 1024,
    parameter int FWD_GAP    = 130,
    localparam int IW        = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_valid,
    input  logic [63:0] int_prefix,
    input  logic [5:0]  int_len,
    input  logic [1:0]  int_face,
    output logic        int_ready,
    output logic        int_dup,
    output logic        int_drop,
    output logic [63:0] fib_prefix,
    output logic [5:0]  fib_len,
    output logic        fib_out_bit,
    input  logic        prefix_ready,
    input  logic [63:0] data_prefix,
    input  logic [5:0]  data_len,
    input  logic [7:0]  data_in,
    output logic        start_send_to_pit,
    output logic        rejected,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        out_first,
    output logic        out_last,
    output logic [3:0]  out_faces,
    output logic [IW:0] pit_count
);
    localparam int GW = $clog2(FWD_GAP + 1);
    localparam int CW = $clog2(DATA_BYTES);

    typedef enum logic [1:0] {I_IDLE, I_LOOK, I_FWD} i_state_e;
    typedef enum logic [1:0] {D_IDLE, D_MATCH, D_ACK, D_RECV} d_state_e;

    i_state_e i_state_q, i_state_d;
    d_state_e d_state_q, d_state_d;

    logic [ENTRIES-1:0] valid_q, lock_q;
    logic [63:0]        prefix_q [ENTRIES];
    logic [5:0]         len_q    [ENTRIES];
    logic [3:0]         faces_q  [ENTRIES];

    logic [63:0]   i_prefix_q;
    logic [5:0]    i_len_q;
    logic [1:0]    i_face_q;
    logic [GW-1:0] gap_q;
    logic          dup_q, drop_q;

    logic [63:0]   d_prefix_q;
    logic [5:0]    d_len_q;
    logic [IW-1:0] d_idx_q;
    logic [CW-1:0] cnt_q;
    logic          d_hit_q, start_q, rej_q, free_q;
    logic          out_valid_q, out_first_q, out_last_q;
    logic [7:0]    out_byte_q;
    logic [3:0]    out_faces_q;

    logic          i_hit, i_free_found, d_hit;
    logic [IW-1:0] i_hit_idx, i_free_idx, d_hit_idx;
    logic          alloc, dup_ev, lock_ev, last_byte;
    logic [3:0]    face_onehot;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        i_hit        = 1'b0;
        i_hit_idx    = '0;
        i_free_found = 1'b0;
        i_free_idx   = '0;
        d_hit        = 1'b0;
        d_hit_idx    = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if (valid_q[k] && !lock_q[k] && len_q[k] == i_len_q && prefix_q[k] == i_prefix_q) begin
                i_hit     = 1'b1;
                i_hit_idx = IW'(k);
            end
            if (!valid_q[k]) begin
                i_free_found = 1'b1;
                i_free_idx   = IW'(k);
            end
            if (valid_q[k] && !lock_q[k] && len_q[k] == d_len_q && prefix_q[k] == d_prefix_q) begin
                d_hit     = 1'b1;
                d_hit_idx = IW'(k);
            end
        end
    end

    assign alloc       = (i_state_q == I_LOOK) && !i_hit && i_free_found;
    assign dup_ev      = (i_state_q == I_LOOK) && i_hit;
    assign lock_ev     = (d_state_q == D_MATCH) && d_hit;
    assign last_byte   = (cnt_q == CW'(DATA_BYTES - 1));
    assign face_onehot = 4'b0001 << i_face_q;

    always_comb begin
        i_state_d   = i_state_q;
        int_ready   = 1'b0;
        fib_out_bit = 1'b0;
        unique case (i_state_q)
            I_IDLE: begin
                int_ready = 1'b1;
                if (int_valid) i_state_d = I_LOOK;
            end
            I_LOOK:  i_state_d = alloc ? I_FWD : I_IDLE;
            I_FWD: begin
                if (gap_q == '0) begin
                    fib_out_bit = 1'b1;
                    i_state_d   = I_IDLE;
                end
            end
            default: i_state_d = I_IDLE;
        endcase
    end

    always_comb begin
        d_state_d = d_state_q;
        unique case (d_state_q)
            D_IDLE:  if (prefix_ready) d_state_d = D_MATCH;
            D_MATCH: d_state_d = D_ACK;
            D_ACK:   d_state_d = d_hit_q ? D_RECV : D_IDLE;
            D_RECV:  if (last_byte) d_state_d = D_IDLE;
            default: d_state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state_q  <= I_IDLE;
            i_prefix_q <= '0;
            i_len_q    <= '0;
            i_face_q   <= '0;
            gap_q      <= '0;
            dup_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            if (int_valid && int_ready) begin
                i_prefix_q <= int_prefix;
                i_len_q    <= int_len;
                i_face_q   <= int_face;
            end
            dup_q  <= dup_ev;
            drop_q <= (i_state_q == I_LOOK) && !i_hit && !i_free_found;
            if (fib_out_bit)      gap_q <= GW'(FWD_GAP - 1);
            else if (gap_q != '0) gap_q <= gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state_q   <= D_IDLE;
            d_prefix_q  <= '0;
            d_len_q     <= '0;
            d_idx_q     <= '0;
            d_hit_q     <= 1'b0;
            start_q     <= 1'b0;
            rej_q       <= 1'b0;
            free_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_byte_q  <= '0;
            out_faces_q <= '0;
        end else begin
            d_state_q   <= d_state_d;
            start_q     <= 1'b0;
            rej_q       <= 1'b0;
            free_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (d_state_q == D_IDLE && prefix_ready) begin
                d_prefix_q <= data_prefix;
                d_len_q    <= data_len;
            end
            if (d_state_q == D_MATCH) begin
                d_hit_q <= d_hit;
                start_q <= d_hit;
                rej_q   <= !d_hit;
                if (d_hit) begin
                    d_idx_q     <= d_hit_idx;
                    out_faces_q <= faces_q[d_hit_idx];
                end
            end
            // The entry is released one edge after the last capture, alongside out_last.
            if (d_state_q == D_RECV) begin
                out_valid_q <= 1'b1;
                out_byte_q  <= data_in;
                out_first_q <= (cnt_q == '0);
                out_last_q  <= last_byte;
                free_q      <= last_byte;
                cnt_q       <= last_byte ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            lock_q  <= '0;
        end else begin
            if (alloc) begin
                valid_q[i_free_idx] <= 1'b1;
                lock_q[i_free_idx]  <= 1'b0;
            end
            if (lock_ev) lock_q[d_hit_idx] <= 1'b1;
            if (free_q) begin
                valid_q[d_idx_q] <= 1'b0;
                lock_q[d_idx_q]  <= 1'b0;
            end
        end
    end

    // NOTE: entry payload fields are not reset; valid_q gates every read of them.
    always_ff @(posedge clk) begin
        if (alloc) begin
            prefix_q[i_free_idx] <= i_prefix_q;
            len_q[i_free_idx]    <= i_len_q;
            faces_q[i_free_idx]  <= face_onehot;
        end else if (dup_ev && !(lock_ev && d_hit_idx == i_hit_idx)) begin
            faces_q[i_hit_idx] <= faces_q[i_hit_idx] | face_onehot;
        end
    end

    always_comb begin
        pit_count = '0;
        for (int k = 0; k < ENTRIES; k++) pit_count = pit_count + {{IW{1'b0}}, valid_q[k]};
    end

    assign int_dup           = dup_q;
    assign int_drop          = drop_q;
    assign fib_prefix        = fib_out_bit ? i_prefix_q : '0;
    assign fib_len           = fib_out_bit ? i_len_q : '0;
    assign start_send_to_pit = start_q;
    assign rejected          = rej_q;
    assign out_valid         = out_valid_q;
    assign out_byte          = out_byte_q;
    assign out_first         = out_first_q;
    assign out_last          = out_last_q;
    assign out_faces         = out_faces_q;

endmodule

// File: doc/pit_table.md
# pit_table

Pending Interest Table for the NDN router: records outstanding interests, forwards new ones to the FIB for longest-prefix routing, and acts as the PIT end of the FIB data handshake. For each returning data packet it answers the FIB's prefix query with `start_send_to_pit` or `rejected`, receives the payload bytes, streams them out tagged with the requesting faces, then frees the entry.

## Interface
- `ENTRIES`, 8: PIT entries; index width `IW=$clog2(ENTRIES)`.
- `DATA_BYTES`, 1024: payload bytes per data packet.
- `FWD_GAP`, 130: minimum cycles between `fib_out_bit` pulses, covering a worst-case FIB search.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `int_valid` in 1: interest offered.
- `int_prefix` in 64: interest name prefix.
- `int_len` in 6: interest prefix length.
- `int_face` in 2: arrival face.
- `int_ready` out 1: interest accepted on a cycle where `int_valid && int_ready`.
- `int_dup` out 1: 1-cycle pulse; the interest was aggregated into an existing entry.
- `int_drop` out 1: 1-cycle pulse; the interest was dropped because the PIT was full.
- `fib_prefix` out 64: prefix to the FIB (`pit_in_prefix`).
- `fib_len` out 6: length to the FIB (`pit_in_len`).
- `fib_out_bit` out 1: 1-cycle FIB lookup request.
- `prefix_ready` in 1: FIB data-prefix query strobe.
- `data_prefix` in 64: data prefix from the FIB.
- `data_len` in 6: data length from the FIB.
- `data_in` in 8: payload byte from the FIB.
- `start_send_to_pit` out 1: 1-cycle accept pulse.
- `rejected` out 1: 1-cycle reject pulse.
- `out_valid` out 1: payload byte valid.
- `out_byte` out 8: payload byte.
- `out_first` out 1: first-byte marker, qualified by `out_valid`.
- `out_last` out 1: last-byte marker, qualified by `out_valid`.
- `out_faces` out 4: one-hot-OR of faces to deliver to; held for the whole packet.
- `pit_count` out IW+1: number of valid entries.

## Operation
- Each entry holds `valid`, `lock`, `prefix[63:0]`, `len[5:0]`, and `faces[3:0]`.
- An entry matches when it is valid, not locked, and both `len` and the full 64-bit prefix are equal.
- Interest FSM:
  - I_IDLE: `int_ready=1`. On accept, latch prefix, len, and face, then go to I_LOOK.
  - I_LOOK, match: OR `1<<face` into the entry's faces, pulse `int_dup`, go to I_IDLE.
  - I_LOOK, miss with a free entry: write the lowest free index with `faces=1<<face` and `lock=0`, go to I_FWD.
  - I_LOOK, miss with the PIT full: pulse `int_drop`, go to I_IDLE.
  - I_FWD: wait until the gap counter is 0. Then drive `fib_prefix`/`fib_len` and `fib_out_bit=1` for exactly one cycle, load the gap counter with FWD_GAP-1, and go to I_IDLE.
- Data FSM:
  - D_IDLE: on `prefix_ready`, latch `data_prefix`/`data_len` and go to D_MATCH.
  - D_MATCH, hit: set the lowest matching entry's lock, latch its faces into `out_faces`, register `start_send_to_pit`, go to D_ACK.
  - D_MATCH, miss: register `rejected`, go to D_ACK.
  - D_ACK: the pulse is high this cycle. Go to D_RECV on hit, D_IDLE on miss.
  - D_RECV: capture `data_in` into `out_byte` each cycle and count 0..DATA_BYTES-1. After the last capture, clear the entry's valid and lock and go to D_IDLE.
- `prefix_ready` is ignored outside D_IDLE.
- A locked entry never matches. An interest for a name being received therefore allocates a new entry and is forwarded to the FIB again.
- Simultaneous events:
  - An entry freed at an edge is free for allocation from the next cycle.
  - If I_LOOK allocates and D_MATCH locks in the same cycle, lookups use pre-edge state; a newly written entry is not visible to that D_MATCH.
  - If the interest path ORs a face in the same edge the data path locks that entry, the lock wins. The late face is lost and `int_dup` still pulses.
- Reset mid-operation: every entry becomes invalid, both FSMs and the gap counter go idle/0, and a partial packet is abandoned with no `out_last`.

## Timing
- Reset values: every output is 0 except `int_ready=1`.
- Interest accepted at edge E:
  - I_LOOK occupies cycle E+1.
  - `int_dup`/`int_drop` are high in cycle E+2.
  - `fib_out_bit` is high no earlier than cycle E+2, and at least FWD_GAP cycles after the previous pulse.
  - `int_ready` returns to 1 the cycle after I_LOOK (dup/drop) or after the `fib_out_bit` cycle.
- `prefix_ready` high in cycle P:
  - D_MATCH occupies P+1.
  - `start_send_to_pit` or `rejected` is high in cycle P+2 only.
- Payload:
  - `data_in` is sampled at the ends of cycles P+3 .. P+2+DATA_BYTES.
  - `out_valid` is high in cycles P+4 .. P+3+DATA_BYTES.
  - `out_first` is high in P+4; `out_last` is high in P+3+DATA_BYTES.
  - The entry is free from cycle P+4+DATA_BYTES.
- `pit_count` updates the cycle after allocation or free.

## Test plan
- Reset, then interest `prefix=64'hA5`, `len=8`, `face=1`: `fib_out_bit` high for 1 cycle with `fib_prefix=64'hA5`, `fib_len=8`; `pit_count=1`.
- Repeat the same name on face 3: `int_dup` pulses, no `fib_out_bit`, entry faces become 4'b1010.
- `prefix_ready` with `64'hA5/8`: `start_send_to_pit` high at P+2. Feed `data_in=n[7:0]` for 1024 cycles: 1024 `out_valid` beats, `out_first` on byte 0x00, `out_last` on byte 0xFF (n=1023), `out_faces=4'b1010`, then `pit_count=0`.
- `prefix_ready` with `64'hA5/7` (len mismatch): `rejected` high at P+2, no `out_valid`.
- Nine distinct interests with ENTRIES=8: ninth gives `int_drop`; `pit_count=8`. Two back-to-back misses give `fib_out_bit` pulses exactly FWD_GAP cycles apart.
- Assert `rst` at payload byte 500: all outputs 0 and `pit_count=0` asynchronously. A fresh interest afterward re-allocates entry 0.
